// File: rtl/operand_read_scheduler_pkg.sv
// Shared types and helpers for the operand read scheduler that multiplexes one VRF read port.
// Build option OPREQ_FIXED_PRIO_EN (consumed by operand_read_scheduler) gives requester 0 absolute priority.
package operand_read_scheduler_pkg;

  localparam int unsigned OpreqNrReq     = 4;
  localparam int unsigned OpreqAddrWidth = 10;

  typedef logic [15:0] vlen_t;

  typedef enum logic [1:0] {
    EW8  = 2'd0,
    EW16 = 2'd1,
    EW32 = 2'd2,
    EW64 = 2'd3
  } vew_e;

  typedef enum logic [2:0] {
    OpQueueConversionNone = 3'd0,
    OpQueueConversionZExt2,
    OpQueueConversionSExt2,
    OpQueueConversionZExt4,
    OpQueueConversionSExt4,
    OpQueueConversionZExt8,
    OpQueueConversionSExt8
  } opqueue_conversion_e;

  typedef struct packed {
    vlen_t               vl;
    vew_e                eew;
    opqueue_conversion_e conv;
  } operand_queue_cmd_t;

  typedef struct packed {
    logic [OpreqAddrWidth-1:0] addr;
    vlen_t                     vl;
    vew_e                      eew;
    opqueue_conversion_e       conv;
  } opreq_req_t;

  typedef enum logic {
    OPREQ_IDLE = 1'b0,
    OPREQ_BUSY = 1'b1
  } opreq_state_e;

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

  // 64-bit VRF words covering vl elements of the source width: ceil(vl * bytes / 8).
  function automatic vlen_t words_from_vl(vlen_t vl, vew_e eew);
    logic [18:0] bytes;
    bytes = 19'(vl) << eew;
    return vlen_t'((bytes + 19'd7) >> 3);
  endfunction

endpackage

// File: rtl/operand_read_scheduler_if.sv
// Bundle between the operand requesters / operand queues / VRF bank and the read scheduler.
// Handshakes: a request transfers on the edge where req_valid_i[k] & req_ready_o[k]; opq_cmd_valid_o and
// opq_issued_o are single-cycle pulses with no back-pressure; a VRF read happens when vrf_req_o & vrf_gnt_i.
interface operand_read_scheduler_if #(
  parameter int unsigned NrReq     = operand_read_scheduler_pkg::OpreqNrReq,
  parameter int unsigned AddrWidth = operand_read_scheduler_pkg::OpreqAddrWidth
);
  import operand_read_scheduler_pkg::*;

  localparam int unsigned IdxW = idx_width(NrReq);

  opreq_req_t         [NrReq-1:0] req_i;
  logic               [NrReq-1:0] req_valid_i;
  logic               [NrReq-1:0] req_ready_o;
  operand_queue_cmd_t [NrReq-1:0] opq_cmd_o;
  logic               [NrReq-1:0] opq_cmd_valid_o;
  logic               [NrReq-1:0] opq_ready_i;
  logic               [NrReq-1:0] opq_issued_o;
  logic                           vrf_req_o;
  logic               [AddrWidth-1:0] vrf_addr_o;
  logic                           vrf_gnt_i;
  logic               [IdxW-1:0]  vrf_dst_o;
  opreq_state_e       [NrReq-1:0] dbg_state_o;

  modport master (
    output req_i, req_valid_i, opq_ready_i, vrf_gnt_i,
    input  req_ready_o, opq_cmd_o, opq_cmd_valid_o, opq_issued_o,
           vrf_req_o, vrf_addr_o, vrf_dst_o, dbg_state_o
  );

  modport slave (
    input  req_i, req_valid_i, opq_ready_i, vrf_gnt_i,
    output req_ready_o, opq_cmd_o, opq_cmd_valid_o, opq_issued_o,
           vrf_req_o, vrf_addr_o, vrf_dst_o, dbg_state_o
  );

endinterface

// File: rtl/opreq_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or after the pointer, returns one-hot and index.
module opreq_rr_arbiter #(
  parameter int unsigned NrReq = 4,
  parameter int unsigned IdxW  = 2
) (
  input  logic [NrReq-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [NrReq-1:0] gnt_o,
  output logic [IdxW-1:0]  idx_o
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NrReq; i++) begin
      cand = IdxW'((32'(ptr_i) + i) % NrReq);
      if (!found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_read_scheduler.sv
// Shares one VRF read port among NrReq operand requesters, honouring each operand queue's credit.
// Define OPREQ_FIXED_PRIO_EN to let requester 0 win whenever eligible (others stay round-robin).
module operand_read_scheduler
  import operand_read_scheduler_pkg::*;
#(
  parameter int unsigned NrReq     = OpreqNrReq,
  parameter int unsigned AddrWidth = OpreqAddrWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  operand_read_scheduler_if.slave bus
);

  localparam int unsigned IdxW = idx_width(NrReq);
  localparam logic [NrReq-1:0] Req0Mask = NrReq'(1);

  typedef logic [AddrWidth-1:0] addr_t;

  opreq_state_e       state_q [NrReq];
  opreq_state_e       state_d [NrReq];
  addr_t              addr_q  [NrReq];
  addr_t              addr_d  [NrReq];
  vlen_t              rem_q   [NrReq];
  vlen_t              rem_d   [NrReq];
  operand_queue_cmd_t cmd_q   [NrReq];
  operand_queue_cmd_t cmd_d   [NrReq];
  logic [NrReq-1:0]   cmd_valid_q, cmd_valid_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;

  logic [NrReq-1:0] eligible, arb_req, arb_gnt, winner_oh, issued;
  logic [IdxW-1:0]  arb_idx, winner_idx;
  logic             vrf_req, grant, advance_ptr;

  // Reset gates eligibility so an in-flight transfer produces no pulse during the reset cycle.
  always_comb begin
    eligible = '0;
    for (int k = 0; k < NrReq; k++) begin
      eligible[k] = !rst_i && (state_q[k] == OPREQ_BUSY) && (rem_q[k] != '0) && bus.opq_ready_i[k];
    end
  end

  opreq_rr_arbiter #(
    .NrReq (NrReq),
    .IdxW  (IdxW)
  ) i_arb (
    .req_i (arb_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

`ifdef OPREQ_FIXED_PRIO_EN
  assign arb_req = eligible & ~Req0Mask;

  always_comb begin
    winner_oh  = arb_gnt;
    winner_idx = arb_idx;
    if (eligible[0]) begin
      winner_oh  = Req0Mask;
      winner_idx = '0;
    end
  end

  assign advance_ptr = grant && (winner_idx != '0);
`else
  assign arb_req     = eligible;
  assign winner_oh   = arb_gnt;
  assign winner_idx  = arb_idx;
  assign advance_ptr = grant;
`endif

  assign vrf_req = |eligible;
  assign grant   = vrf_req & bus.vrf_gnt_i;
  assign issued  = grant ? winner_oh : '0;

  assign bus.vrf_req_o       = vrf_req;
  assign bus.vrf_addr_o      = vrf_req ? addr_q[winner_idx] : '0;
  assign bus.vrf_dst_o       = vrf_req ? winner_idx : '0;
  assign bus.opq_issued_o    = issued;
  assign bus.opq_cmd_valid_o = cmd_valid_q;

  always_comb begin
    bus.req_ready_o = '0;
    bus.opq_cmd_o   = '0;
    bus.dbg_state_o = '0;
    for (int k = 0; k < NrReq; k++) begin
      bus.req_ready_o[k] = (state_q[k] == OPREQ_IDLE);
      bus.opq_cmd_o[k]   = cmd_q[k];
      bus.dbg_state_o[k] = state_q[k];
    end
  end

  // Requester FSMs, address/remaining counters and the round-robin pointer.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    cmd_d       = cmd_q;
    cmd_valid_d = '0;
    rr_ptr_d    = rr_ptr_q;
    for (int k = 0; k < NrReq; k++) begin
      unique case (state_q[k])
        OPREQ_IDLE: begin
          if (bus.req_valid_i[k] && (bus.req_i[k].vl != '0)) begin
            state_d[k]     = OPREQ_BUSY;
            addr_d[k]      = addr_t'(bus.req_i[k].addr);
            rem_d[k]       = words_from_vl(bus.req_i[k].vl, bus.req_i[k].eew);
            cmd_d[k]       = '{vl: bus.req_i[k].vl, eew: bus.req_i[k].eew, conv: bus.req_i[k].conv};
            cmd_valid_d[k] = 1'b1;
          end
        end
        OPREQ_BUSY: begin
          if (issued[k]) begin
            addr_d[k] = addr_q[k] + 1'b1;
            rem_d[k]  = rem_q[k] - 1'b1;
            if (rem_q[k] == vlen_t'(1)) state_d[k] = OPREQ_IDLE;
          end
        end
        default: state_d[k] = OPREQ_IDLE;
      endcase
    end
    if (advance_ptr) begin
      rr_ptr_d = (winner_idx == IdxW'(NrReq - 1)) ? '0 : winner_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NrReq; k++) begin
        state_q[k] <= OPREQ_IDLE;
        addr_q[k]  <= '0;
        rem_q[k]   <= '0;
        cmd_q[k]   <= '0;
      end
      cmd_valid_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_operand_read_scheduler.sv
// Scoreboard bench for operand_read_scheduler: directed scenarios plus random traffic.
// Grant-order expectations follow OPREQ_FIXED_PRIO_EN when the bench is built with it.
module tb_operand_read_scheduler;
  import operand_read_scheduler_pkg::*;

  localparam int unsigned NR = OpreqNrReq;
  localparam int unsigned AW = OpreqAddrWidth;
  localparam int unsigned IW = idx_width(NR);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  operand_read_scheduler_if bus ();

  operand_read_scheduler dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog no summary reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [AW-1:0]      exp_addr_q [NR][$];
  operand_queue_cmd_t exp_cmd_q  [NR][$];
  logic [IW-1:0]      gnt_log[$];
  int                 gnt_cyc[$];
  int                 cmd_cyc[$];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit queues_empty();
    bit e = 1'b1;
    for (int k = 0; k < NR; k++) begin
      if (exp_addr_q[k].size() != 0 || exp_cmd_q[k].size() != 0) e = 1'b0;
    end
    return e;
  endfunction

  // Monitor: compares every read and cmd push against the expected queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.opq_issued_o != '0) begin
        check("issued_onehot", 64'($onehot(bus.opq_issued_o)), 64'(1));
        check("issued_vs_req", 64'(bus.vrf_req_o), 64'(1));
        check("issued_vs_gnt", 64'(bus.vrf_gnt_i), 64'(1));
        check("issued_masked", 64'(bus.opq_issued_o & ~bus.opq_ready_i), 64'(0));
        check("issued_dst", 64'(bus.opq_issued_o[bus.vrf_dst_o]), 64'(1));
        gnt_log.push_back(bus.vrf_dst_o);
        gnt_cyc.push_back(cyc);
        check("rd_expected", 64'(exp_addr_q[bus.vrf_dst_o].size() != 0), 64'(1));
        if (exp_addr_q[bus.vrf_dst_o].size() != 0)
          check($sformatf("rd_addr_%0d", bus.vrf_dst_o), 64'(bus.vrf_addr_o),
                64'(exp_addr_q[bus.vrf_dst_o].pop_front()));
      end
      for (int k = 0; k < NR; k++) begin
        if (bus.opq_cmd_valid_o[k]) begin
          cmd_cyc.push_back(cyc);
          check("cmd_expected", 64'(exp_cmd_q[k].size() != 0), 64'(1));
          if (exp_cmd_q[k].size() != 0)
            check($sformatf("cmd_%0d", k), 64'(bus.opq_cmd_o[k]), 64'(exp_cmd_q[k].pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    bus.req_valid_i = '0;
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    gnt_cyc.delete();
    cmd_cyc.delete();
  endtask

  task automatic clear_expect();
    for (int k = 0; k < NR; k++) begin
      exp_addr_q[k].delete();
      exp_cmd_q[k].delete();
    end
  endtask

  task automatic apply_reset();
    rst             = 1'b1;
    bus.req_valid_i = '0;
    bus.opq_ready_i = '1;
    bus.vrf_gnt_i   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_expect();
    clear_logs();
  endtask

  task automatic set_req(int k, logic [AW-1:0] addr, vlen_t vl, vew_e eew, opqueue_conversion_e conv);
    int words;
    check($sformatf("ready_%0d", k), 64'(bus.req_ready_o[k]), 64'(1));
    bus.req_i[k]       = '{addr: addr, vl: vl, eew: eew, conv: conv};
    bus.req_valid_i[k] = 1'b1;
    if (vl != '0) begin
      exp_cmd_q[k].push_back('{vl: vl, eew: eew, conv: conv});
      words = (int'(vl) * (1 << int'(eew)) + 7) / 8;
      for (int w = 0; w < words; w++) exp_addr_q[k].push_back(addr + AW'(w));
    end
  endtask

  task automatic wait_idle(int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      done = (bus.req_ready_o == '1) && queues_empty();
      if (!done) tick();
    end
    check("drain", 64'(done), 64'(1));
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_ready"}, 64'(bus.req_ready_o), 64'({NR{1'b1}}));
    check({tag, "_cmd_valid"}, 64'(bus.opq_cmd_valid_o), 64'(0));
    check({tag, "_issued"}, 64'(bus.opq_issued_o), 64'(0));
    check({tag, "_vrf_req"}, 64'(bus.vrf_req_o), 64'(0));
    check({tag, "_vrf_addr"}, 64'(bus.vrf_addr_o), 64'(0));
    check({tag, "_vrf_dst"}, 64'(bus.vrf_dst_o), 64'(0));
    check({tag, "_state"}, 64'(bus.dbg_state_o), 64'(0));
    for (int k = 0; k < NR; k++) check({tag, "_cmd"}, 64'(bus.opq_cmd_o[k]), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    bus.req_i       = '0;
    bus.req_valid_i = '0;
    bus.opq_ready_i = '1;
    bus.vrf_gnt_i   = 1'b1;
    apply_reset();
    check_reset_outputs("rst");

    // 1: single 8-word request, timing of cmd, reads and ready
    set_req(0, 5, 8, EW64, OpQueueConversionNone);
    tick();
    t0 = cyc;
    repeat (7) tick();
    check("t1_busy_last", 64'(bus.req_ready_o[0]), 64'(0));
    tick();
    check("t1_ready_back", 64'(bus.req_ready_o[0]), 64'(1));
    check("t1_nreads", 64'(gnt_log.size()), 64'(8));
    if (gnt_cyc.size() == 8) begin
      check("t1_first_cyc", 64'(gnt_cyc[0]), 64'(t0));
      check("t1_last_cyc", 64'(gnt_cyc[7]), 64'(t0 + 7));
    end
    check("t1_ncmd", 64'(cmd_cyc.size()), 64'(1));
    if (cmd_cyc.size() == 1) check("t1_cmd_cyc", 64'(cmd_cyc[0]), 64'(t0));

    // 2: two requesters accepted together from a fresh pointer
    apply_reset();
    set_req(0, 100, 4, EW64, OpQueueConversionNone);
    set_req(1, 200, 4, EW64, OpQueueConversionNone);
    tick();
    wait_idle(40);
    check("t2_nreads", 64'(gnt_log.size()), 64'(8));
    for (int i = 0; i < gnt_log.size() && i < 8; i++) begin
`ifdef OPREQ_FIXED_PRIO_EN
      check("t2_order", 64'(gnt_log[i]), 64'((i < 4) ? 0 : 1));
`else
      check("t2_order", 64'(gnt_log[i]), 64'(i % 2));
`endif
    end

    // 3: narrow conversion read, 3 bytes fit one word
    clear_logs();
    set_req(2, 50, 3, EW8, OpQueueConversionSExt8);
    tick();
    wait_idle(20);
    check("t3_nreads", 64'(gnt_log.size()), 64'(1));

    // 4: queue 1 out of credit for 5 cycles while requester 3 keeps going
    clear_logs();
    bus.opq_ready_i[1] = 1'b0;
    set_req(3, 300, 16, EW64, OpQueueConversionNone);
    set_req(1, 400, 4, EW64, OpQueueConversionNone);
    tick();
    repeat (5) tick();
    check("t4_stall_reads", 64'(gnt_log.size()), 64'(5));
    for (int i = 0; i < gnt_log.size(); i++) check("t4_stall_dst", 64'(gnt_log[i]), 64'(3));
    check("t4_req1_busy", 64'(bus.dbg_state_o[1]), 64'(OPREQ_BUSY));
    bus.opq_ready_i[1] = 1'b1;
    wait_idle(60);
    check("t4_nreads", 64'(gnt_log.size()), 64'(20));

    // 5: VRF bank denies for 3 cycles, across an address wrap
    clear_logs();
    set_req(0, 1020, 6, EW64, OpQueueConversionNone);
    bus.vrf_gnt_i = 1'b0;
    tick();
    t0 = cyc;
    repeat (3) tick();
    check("t5_no_reads", 64'(gnt_log.size()), 64'(0));
    check("t5_state", 64'(bus.dbg_state_o[0]), 64'(OPREQ_BUSY));
    check("t5_req_held", 64'(bus.vrf_req_o), 64'(1));
    check("t5_addr_frozen", 64'(bus.vrf_addr_o), 64'(1020));
    bus.vrf_gnt_i = 1'b1;
    wait_idle(30);
    check("t5_nreads", 64'(gnt_log.size()), 64'(6));
    if (gnt_cyc.size() == 6) begin
      check("t5_first_cyc", 64'(gnt_cyc[0]), 64'(t0 + 3));
      check("t5_last_cyc", 64'(gnt_cyc[5]), 64'(t0 + 8));
    end

    // 6a: vl == 0 is accepted and dropped
    clear_logs();
    set_req(1, 7, 0, EW64, OpQueueConversionNone);
    tick();
    check("t6_vl0_ready", 64'(bus.req_ready_o[1]), 64'(1));
    check("t6_vl0_state", 64'(bus.dbg_state_o[1]), 64'(OPREQ_IDLE));
    repeat (3) tick();
    check("t6_vl0_reads", 64'(gnt_log.size()), 64'(0));
    check("t6_vl0_cmds", 64'(cmd_cyc.size()), 64'(0));

    // 6b: reset in the middle of a transfer
    set_req(2, 10, 20, EW64, OpQueueConversionNone);
    tick();
    repeat (3) tick();
    check("t6_reads_before_rst", 64'(gnt_log.size()), 64'(3));
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_issued", 64'(bus.opq_issued_o), 64'(0));
    check("t6_rst_vrf_req", 64'(bus.vrf_req_o), 64'(0));
    @(posedge clk);
    #1;
    check_reset_outputs("t6_rst");
    rst = 1'b0;
    clear_expect();
    clear_logs();
    tick();
    check("t6_after_rst_idle", 64'(bus.vrf_req_o), 64'(0));

    // random traffic with random credits and bank denials
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NR; k++) begin
        if (bus.req_ready_o[k] && $urandom_range(0, 3) == 0)
          set_req(k, AW'($urandom_range(0, 1023)), vlen_t'($urandom_range(0, 6)),
                  vew_e'($urandom_range(0, 3)), OpQueueConversionNone);
      end
      bus.opq_ready_i = NR'($urandom_range(0, (1 << NR) - 1));
      bus.vrf_gnt_i   = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.opq_ready_i = '1;
    bus.vrf_gnt_i   = 1'b1;
    wait_idle(200);

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
